// File: rtl/aes_core_sched.sv
// aes_core_sched: round-robin scheduler for a shared AES core between two requesters.
// It arbitrates one job at a time and reloads the key schedule whenever the cached
// key cannot be reused. It aborts with a one-cycle error pulse if the key expansion
// or the AES block does not finish within TIMEOUT cycles.
module aes_core_sched #(
    parameter int TIMEOUT = 64,
    parameter int CW      = 7
) (
    input  logic       hclk,
    input  logic       hrst,
    input  logic [1:0] req,
    input  logic [1:0] req_encrypt,
    input  logic [1:0] req_key_chg,
    input  logic       key_done,
    input  logic       aes_done,
    output logic [1:0] grant,
    output logic       encrypt,
    output logic       key_load,
    output logic       aes_start,
    output logic [1:0] job_done,
    output logic       job_err,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_KEY   = 3'd1,
        S_KWAIT = 3'd2,
        S_START = 3'd3,
        S_RUN   = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    state_t        r_state;
    logic          r_ptr;        // preferred requester for the next grant
    logic          r_win;        // requester owning the current job
    logic          r_key_valid;  // expanded key schedule is usable
    logic          r_key_owner;  // requester whose key is currently expanded
    logic [CW-1:0] r_cnt;        // cycles spent waiting in KWAIT or RUN

    logic          w_win;
    logic          w_key_need;
    logic          w_expire;

    // Winner selection, key-reuse decision and timeout detection
    always_comb begin
        w_win      = 1'b0;
        w_key_need = 1'b1;
        w_expire   = 1'b0;
        if (req[r_ptr]) begin
            w_win = r_ptr;
        end else begin
            w_win = ~r_ptr;
        end
        w_key_need = ~r_key_valid | (r_key_owner != w_win) | req_key_chg[w_win];
        w_expire   = (r_cnt == CW'(TIMEOUT - 1));
    end

    // Scheduler FSM with all outputs registered alongside the state
    always_ff @(posedge hclk or posedge hrst) begin
        if (hrst) begin
            r_state     <= S_IDLE;
            r_ptr       <= 1'b0;
            r_win       <= 1'b0;
            r_key_valid <= 1'b0;
            r_key_owner <= 1'b0;
            r_cnt       <= '0;
            grant       <= 2'b00;
            encrypt     <= 1'b0;
            key_load    <= 1'b0;
            aes_start   <= 1'b0;
            job_done    <= 2'b00;
            job_err     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            // pulses default low; each state raises the one it owns
            key_load  <= 1'b0;
            aes_start <= 1'b0;
            job_done  <= 2'b00;
            job_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (|req) begin
                        r_win   <= w_win;
                        grant   <= w_win ? 2'b10 : 2'b01;
                        encrypt <= req_encrypt[w_win];
                        busy    <= 1'b1;
                        if (w_key_need) begin
                            r_state  <= S_KEY;
                            key_load <= 1'b1;
                        end else begin
                            r_state   <= S_START;
                            aes_start <= 1'b1;
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                S_KEY: begin
                    r_state <= S_KWAIT;
                    r_cnt   <= '0;
                end
                S_KWAIT: begin
                    if (key_done) begin
                        r_key_valid <= 1'b1;
                        r_key_owner <= r_win;
                        r_state     <= S_START;
                        aes_start   <= 1'b1;
                    end else if (w_expire) begin
                        r_state     <= S_ERR;
                        job_err     <= 1'b1;
                        grant       <= 2'b00;
                        encrypt     <= 1'b0;
                        r_key_valid <= 1'b0;
                        r_ptr       <= ~r_win;
                    end else begin
                        r_cnt <= r_cnt + CW'(1'b1);
                    end
                end
                S_START: begin
                    r_state <= S_RUN;
                    r_cnt   <= '0;
                end
                S_RUN: begin
                    // a done arriving on the expiry cycle still completes the job
                    if (aes_done) begin
                        r_state  <= S_DONE;
                        job_done <= r_win ? 2'b10 : 2'b01;
                        grant    <= 2'b00;
                        encrypt  <= 1'b0;
                        r_ptr    <= ~r_win;
                    end else if (w_expire) begin
                        r_state     <= S_ERR;
                        job_err     <= 1'b1;
                        grant       <= 2'b00;
                        encrypt     <= 1'b0;
                        r_key_valid <= 1'b0;
                        r_ptr       <= ~r_win;
                    end else begin
                        r_cnt <= r_cnt + CW'(1'b1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
                S_ERR: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    grant   <= 2'b00;
                    encrypt <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/aes_core_sched.md
AES_CORE_SCHED -- requirements
Module: aes_core_sched

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64: max cycles waited for key_done or aes_done before abort.
REQ-002 SHALL have parameter CW, default 7: timeout counter width, at least clog2(TIMEOUT+1).
REQ-003 SHALL have ports, one per line:
  hclk  in  1  single clock, all state on rising edge
  hrst  in  1  reset, asynchronous and active-high
  req  in  2  per-requester job request, held high until its job_done or job_err
  req_encrypt  in  2  per-requester mode, 1=encrypt 0=decrypt
  req_key_chg  in  2  per-requester demand for key re-expansion
  key_done  in  1  key expansion complete pulse
  aes_done  in  1  AES block complete pulse
  grant  out  2  one-hot owner of the AES core
  encrypt  out  1  mode driven to AES core, valid while grant!=0
  key_load  out  1  one-cycle key expansion start pulse
  aes_start  out  1  one-cycle AES start pulse
  job_done  out  2  one-cycle per-requester completion pulse
  job_err  out  1  one-cycle timeout abort pulse
  busy  out  1  high in every state except IDLE

Function
REQ-004 SHALL implement FSM states IDLE, KEY, KWAIT, START, RUN, DONE, ERR.
REQ-005 IDLE: with any req bit high, SHALL latch winner, owner mode and key-need, set grant one-hot, and go to KEY if key needed, else START.
REQ-006 Winner SHALL be chosen round-robin: 1-bit pointer names the preferred requester; the other wins only if the preferred is idle.
REQ-007 Key needed SHALL be key_valid==0 OR key_owner!=winner OR req_key_chg[winner]==1.
REQ-008 KEY: key_load=1 for exactly this cycle; next state KWAIT.
REQ-009 KWAIT: key_done=1 SHALL set key_valid=1, key_owner=winner, go to START; counter expiry goes to ERR.
REQ-010 START: aes_start=1 for exactly this cycle; next state RUN.
REQ-011 RUN: aes_done=1 goes to DONE; counter expiry goes to ERR.
REQ-012 Timeout counter SHALL clear on entering KWAIT or RUN and increment each cycle there, saturating; expiry is count==TIMEOUT-1 without the awaited done.
REQ-013 When the awaited done and expiry coincide, done SHALL win; no error.
REQ-014 DONE: grant=0, job_done[winner]=1 for this cycle, pointer set to the other requester, next IDLE.
REQ-015 ERR: grant=0, job_err=1 for this cycle, key_valid cleared, pointer set to the other requester, next IDLE.
REQ-016 grant and encrypt SHALL stay constant from grant cycle through RUN; req or req_encrypt changes mid-job are ignored.
REQ-017 key_done or aes_done outside KWAIT/RUN SHALL be ignored.
REQ-018 Latency with key valid: req sampled at edge N -> grant, aes_start high in cycle N+1; aes_done at cycle M -> job_done in cycle M+1; IDLE again at M+2.
REQ-019 A requester SHALL NOT be granted in the same cycle as its job_done; back-to-back jobs pass through IDLE (one idle cycle minimum).

Reset
REQ-020 hrst high SHALL force IDLE, grant=0, all pulses 0, busy=0, encrypt=0, pointer=0, key_valid=0, key_owner=0, counter=0, independent of hclk.
REQ-021 Reset mid-job SHALL abandon the job with no job_done or job_err pulse; the first post-reset grant requires a key load.

Verification
REQ-022 After reset, req=01, req_encrypt=01, key_done at 3rd KWAIT cycle, aes_done 12 cycles after aes_start -> grant=01, key_load one cycle, aes_start one cycle, job_done=01 one cycle, encrypt=1 throughout.
REQ-023 Second job from requester 0 (req_key_chg=00) -> no key_load, aes_start the cycle after grant; then req=11 held -> grants alternate 10, 01, 10.
REQ-024 Owner change requester 0 to 1 with req_key_chg=00 -> key_load issued; job on 1 with req_key_chg=10 -> key_load issued despite same owner.
REQ-025 TIMEOUT=64, aes_done never sent -> job_err on RUN cycle 65, grant=00, next job forces key_load; aes_done on the 64th RUN cycle -> job_done, no job_err.
REQ-026 hrst pulsed during RUN -> outputs zero asynchronously, no job_done/job_err; stray aes_done in IDLE -> no response.
